// File: rtl/axi4_lite_master_gen_pkg.sv
// Shared types and constants for the AXI4-Lite master engine.
// Holds the FSM state encoding, response codes and the default protection value.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_gen_if.sv
// AXI4-Lite bus bundle between the master engine and one interconnect port.
// The master modport drives addresses, data and valids; the slave modport answers.
interface axi4_lite_master_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;

    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;

    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;

    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface

// File: rtl/axi4_lite_master_gen_timeout_ctr.sv
// Per-transaction watchdog: counts active cycles and flags the cycle in which
// the TIMEOUT_CYCLES-th active cycle is reached. TIMEOUT_CYCLES=0 disables it.
module axi4_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr, en};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt_q;

            // cnt_q holds completed active cycles, so the current one is the last allowed
            assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                end else if (en && !expired) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axi4_lite_master_gen.sv
// Single-beat AXI4-Lite master: turns a Start pulse into one read or write
// transaction, returns the response, and abandons the transfer on timeout.
module axi4_lite_master_gen
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_W        = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AXI_Start,
    input  logic                  AXI_WriteEn,
    input  logic [ADDR_W-1:0]     AXI_Addr,
    input  logic [DATA_W-1:0]     AXI_WData,
    input  logic [STRB_W-1:0]     AXI_WStrb,
    output logic [DATA_W-1:0]     AXI_RData,
    output logic [1:0]            AXI_Resp,
    output logic                  AXI_Done,
    output logic                  AXI_Busy,
    output logic                  AXI_Timeout,
    axi4_lite_master_gen_if.master m_axi
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              done_q, timeout_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_finished, w_finished;
    logic ctr_en, expired;

    assign aw_hs = awvalid_q & m_axi.AWREADY;
    assign w_hs  = wvalid_q  & m_axi.WREADY;
    assign b_hs  = bready_q  & m_axi.BVALID;
    assign ar_hs = arvalid_q & m_axi.ARREADY;
    assign r_hs  = rready_q  & m_axi.RVALID;

    // A channel counts as finished once its valid has already dropped or handshakes now
    assign aw_finished = !awvalid_q || aw_hs;
    assign w_finished  = !wvalid_q  || w_hs;

    assign ctr_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

    axi4_lite_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!ctr_en),
        .en     (ctr_en),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (AXI_Start) begin
                        addr_q  <= AXI_Addr;
                        wdata_q <= AXI_WData;
                        wstrb_q <= AXI_WStrb;
                        if (AXI_WriteEn) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (expired) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        resp_q    <= DECERR;
                    end else begin
                        if (aw_hs) awvalid_q <= 1'b0;
                        if (w_hs)  wvalid_q  <= 1'b0;
                        if (aw_finished && w_finished) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    // A response arriving in the expiry cycle still completes normally
                    if (b_hs) begin
                        resp_q   <= m_axi.BRESP;
                        bready_q <= 1'b0;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end else if (expired) begin
                        bready_q  <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        resp_q    <= DECERR;
                    end
                end
                ST_RD_ADDR: begin
                    if (expired) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        resp_q    <= DECERR;
                    end else if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        rdata_q  <= m_axi.RDATA;
                        resp_q   <= m_axi.RRESP;
                        rready_q <= 1'b0;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end else if (expired) begin
                        rready_q  <= 1'b0;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        resp_q    <= DECERR;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWPROT  = PROT_DEFAULT;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = wstrb_q;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARPROT  = PROT_DEFAULT;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

    assign AXI_RData   = rdata_q;
    assign AXI_Resp    = resp_q;
    assign AXI_Done    = done_q;
    assign AXI_Busy    = (state_q != ST_IDLE);
    assign AXI_Timeout = timeout_q;

endmodule

// File: tb/tb_axi4_lite_master_gen.sv
// Directed bench for the AXI4-Lite master: a 32-bit instance with a 16-cycle
// timeout and a 64-bit instance with the timeout disabled.
module tb_axi4_lite_master_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_start, a_we;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic [1:0]  a_resp;
    logic        a_done, a_busy, a_to;

    logic        b_start, b_we;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_wstrb;
    logic [1:0]  b_resp;
    logic        b_done, b_busy, b_to;

    int checks = 0;
    int errors = 0;

    axi4_lite_master_gen_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    axi4_lite_master_gen_if #(.ADDR_W(32), .DATA_W(64)) bus_b ();

    axi4_lite_master_gen #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .AXI_Start(a_start), .AXI_WriteEn(a_we), .AXI_Addr(a_addr),
        .AXI_WData(a_wdata), .AXI_WStrb(a_wstrb), .AXI_RData(a_rdata),
        .AXI_Resp(a_resp), .AXI_Done(a_done), .AXI_Busy(a_busy),
        .AXI_Timeout(a_to), .m_axi(bus_a)
    );

    axi4_lite_master_gen #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .AXI_Start(b_start), .AXI_WriteEn(b_we), .AXI_Addr(b_addr),
        .AXI_WData(b_wdata), .AXI_WStrb(b_wstrb), .AXI_RData(b_rdata),
        .AXI_Resp(b_resp), .AXI_Done(b_done), .AXI_Busy(b_busy),
        .AXI_Timeout(b_to), .m_axi(bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({a_busy, a_done, a_to, bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY, bus_a.ARVALID, bus_a.RREADY} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000", {a_busy, a_done, a_to, bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY, bus_a.ARVALID, bus_a.RREADY});
        end
        checks++;
        if (a_resp !== 2'b00 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp_rdata: got resp=%b rdata=%h required 00/00000000", a_resp, a_rdata);
        end
        checks++;
        if (bus_a.AWADDR !== 32'h0 || bus_a.WDATA !== 32'h0 || bus_a.WSTRB !== 4'h0 || bus_a.AWPROT !== 3'b000 || bus_a.ARPROT !== 3'b000) begin
            errors++;
            $display("FAIL reset_payload: got awaddr=%h wdata=%h wstrb=%h required zeros", bus_a.AWADDR, bus_a.WDATA, bus_a.WSTRB);
        end
        $display("reset: outputs inspected after reset release");
    endtask

    task automatic test_write_zero_wait();
        bus_a.AWREADY = 1'b1;
        bus_a.WREADY  = 1'b1;
        a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'hDEADBEEF; a_wstrb = 4'hF; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID, a_busy, a_done} !== 4'b1110) begin
            errors++;
            $display("FAIL wr0_issue: got aw/w/busy/done=%b required 1110", {bus_a.AWVALID, bus_a.WVALID, a_busy, a_done});
        end
        checks++;
        if (bus_a.AWADDR !== 32'h40 || bus_a.WDATA !== 32'hDEADBEEF || bus_a.WSTRB !== 4'hF) begin
            errors++;
            $display("FAIL wr0_payload: got %h/%h/%h required 00000040/deadbeef/f", bus_a.AWADDR, bus_a.WDATA, bus_a.WSTRB);
        end
        tick();
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY, a_done} !== 4'b0010) begin
            errors++;
            $display("FAIL wr0_bready: got aw/w/bready/done=%b required 0010", {bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY, a_done});
        end
        bus_a.BVALID = 1'b1; bus_a.BRESP = 2'b00;
        tick();
        bus_a.BVALID = 1'b0; bus_a.AWREADY = 1'b0; bus_a.WREADY = 1'b0;
        checks++;
        if ({a_done, a_to, bus_a.BREADY, a_busy} !== 4'b1001 || a_resp !== 2'b00) begin
            errors++;
            $display("FAIL wr0_done: got done/to/bready/busy=%b resp=%b required 1001 resp=00", {a_done, a_to, bus_a.BREADY, a_busy}, a_resp);
        end
        tick();
        checks++;
        if ({a_done, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL wr0_idle: got done/busy=%b required 00", {a_done, a_busy});
        end
        $display("write addr=%h data=%h strb=%h resp=%b", a_addr, a_wdata, a_wstrb, a_resp);
    endtask

    task automatic test_write_aw_delay();
        bus_a.AWREADY = 1'b0;
        bus_a.WREADY  = 1'b1;
        a_we = 1'b1; a_addr = 32'h0000_0ABC; a_wdata = 32'h5555_AAAA; a_wstrb = 4'h3; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID} !== 2'b11) begin
            errors++;
            $display("FAIL wrd_issue: got aw/w=%b required 11", {bus_a.AWVALID, bus_a.WVALID});
        end
        tick();
        bus_a.WREADY = 1'b0;
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY} !== 3'b100) begin
            errors++;
            $display("FAIL wrd_wdrop: got aw/w/bready=%b required 100", {bus_a.AWVALID, bus_a.WVALID, bus_a.BREADY});
        end
        // Early BVALID must not be accepted before the AW handshake
        bus_a.BVALID = 1'b1; bus_a.BRESP = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_a.AWVALID !== 1'b1 || bus_a.AWADDR !== 32'h0000_0ABC || bus_a.BREADY !== 1'b0) begin
                errors++;
                $display("FAIL wrd_hold%0d: got awvalid=%b awaddr=%h bready=%b required 1/00000abc/0", k, bus_a.AWVALID, bus_a.AWADDR, bus_a.BREADY);
            end
        end
        bus_a.AWREADY = 1'b1;
        tick();
        bus_a.AWREADY = 1'b0;
        checks++;
        if ({bus_a.AWVALID, bus_a.BREADY, a_done} !== 3'b010) begin
            errors++;
            $display("FAIL wrd_bready: got aw/bready/done=%b required 010", {bus_a.AWVALID, bus_a.BREADY, a_done});
        end
        tick();
        bus_a.BVALID = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_resp !== 2'b01 || bus_a.BREADY !== 1'b0) begin
            errors++;
            $display("FAIL wrd_done: got done=%b resp=%b bready=%b required 1/01/0", a_done, a_resp, bus_a.BREADY);
        end
        tick();
        $display("write addr=%h data=%h (AW delayed) resp=%b", a_addr, a_wdata, a_resp);
    endtask

    task automatic test_read_wait();
        bus_a.ARREADY = 1'b1;
        a_we = 1'b0; a_addr = 32'h1000; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (bus_a.ARVALID !== 1'b1 || bus_a.ARADDR !== 32'h1000 || bus_a.RREADY !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue: got arvalid=%b araddr=%h rready=%b required 1/00001000/0", bus_a.ARVALID, bus_a.ARADDR, bus_a.RREADY);
        end
        tick();
        bus_a.ARREADY = 1'b0;
        checks++;
        if ({bus_a.ARVALID, bus_a.RREADY} !== 2'b01) begin
            errors++;
            $display("FAIL rd_rready: got ar/rready=%b required 01", {bus_a.ARVALID, bus_a.RREADY});
        end
        tick();
        tick();
        checks++;
        if (bus_a.RREADY !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait: got rready=%b done=%b required 1/0", bus_a.RREADY, a_done);
        end
        bus_a.RVALID = 1'b1; bus_a.RDATA = 32'h12345678; bus_a.RRESP = 2'b10;
        tick();
        bus_a.RVALID = 1'b0; bus_a.RDATA = 32'hFFFF_FFFF;
        checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'h12345678 || a_resp !== 2'b10 || bus_a.RREADY !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: got done=%b rdata=%h resp=%b rready=%b required 1/12345678/10/0", a_done, a_rdata, a_resp, bus_a.RREADY);
        end
        tick();
        checks++;
        if (a_done !== 1'b0 || a_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_single_pulse: got done=%b rdata=%h required 0/12345678", a_done, a_rdata);
        end
        $display("read addr=%h rdata=%h resp=%b", a_addr, a_rdata, a_resp);
    endtask

    task automatic test_write_64();
        bus_b.AWREADY = 1'b1;
        bus_b.WREADY  = 1'b1;
        b_we = 1'b1; b_addr = 32'h80; b_wdata = 64'hCAFEBABE_01234567; b_wstrb = 8'h0F; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        checks++;
        if (bus_b.WSTRB !== 8'h0F || bus_b.WDATA !== 64'hCAFEBABE_01234567 || bus_b.WVALID !== 1'b1) begin
            errors++;
            $display("FAIL w64_payload: got wstrb=%h wdata=%h wvalid=%b required 0f/cafebabe01234567/1", bus_b.WSTRB, bus_b.WDATA, bus_b.WVALID);
        end
        tick();
        bus_b.BVALID = 1'b1; bus_b.BRESP = 2'b00;
        tick();
        bus_b.BVALID = 1'b0; bus_b.AWREADY = 1'b0; bus_b.WREADY = 1'b0;
        checks++;
        if (b_done !== 1'b1 || b_resp !== 2'b00 || b_to !== 1'b0) begin
            errors++;
            $display("FAIL w64_done: got done=%b resp=%b to=%b required 1/00/0", b_done, b_resp, b_to);
        end
        tick();
        $display("write64 addr=%h data=%h strb=%h resp=%b", b_addr, b_wdata, b_wstrb, b_resp);
    endtask

    task automatic test_timeout();
        int ar_cycles = 0;
        bit seen_done = 1'b0;
        bus_a.ARREADY = 1'b0;
        a_we = 1'b0; a_addr = 32'h200; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus_a.ARVALID) ar_cycles++;
            tick();
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL to_no_done: got no Done within 40 cycles required Done");
        end
        checks++;
        if (ar_cycles !== 16) begin
            errors++;
            $display("FAIL to_arvalid_cycles: got %0d required 16", ar_cycles);
        end
        checks++;
        if (a_to !== 1'b1 || a_resp !== 2'b11 || bus_a.ARVALID !== 1'b0 || a_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL to_status: got to=%b resp=%b arvalid=%b rdata=%h required 1/11/0/12345678", a_to, a_resp, bus_a.ARVALID, a_rdata);
        end
        tick();
        $display("read addr=%h timed out after %0d cycles resp=%b", a_addr, ar_cycles, a_resp);

        bus_a.ARREADY = 1'b1;
        a_addr = 32'h1004; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        bus_a.ARREADY = 1'b0;
        bus_a.RVALID = 1'b1; bus_a.RDATA = 32'hA5A55A5A; bus_a.RRESP = 2'b00;
        tick();
        bus_a.RVALID = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_to !== 1'b0 || a_rdata !== 32'hA5A55A5A || a_resp !== 2'b00) begin
            errors++;
            $display("FAIL to_recover: got done=%b to=%b rdata=%h resp=%b required 1/0/a5a55a5a/00", a_done, a_to, a_rdata, a_resp);
        end
        tick();
        $display("read addr=%h rdata=%h resp=%b", a_addr, a_rdata, a_resp);
    endtask

    task automatic test_start_ignored();
        bus_a.ARREADY = 1'b0;
        a_we = 1'b0; a_addr = 32'h300; a_start = 1'b1;
        tick();
        a_we = 1'b1; a_addr = 32'h999;
        tick();
        a_start = 1'b0;
        checks++;
        if (bus_a.ARADDR !== 32'h300 || bus_a.AWVALID !== 1'b0 || bus_a.ARVALID !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got araddr=%h awvalid=%b arvalid=%b required 00000300/0/1", bus_a.ARADDR, bus_a.AWVALID, bus_a.ARVALID);
        end
        bus_a.ARREADY = 1'b1;
        tick();
        bus_a.ARREADY = 1'b0;
        bus_a.RVALID = 1'b1; bus_a.RDATA = 32'h0BADF00D; bus_a.RRESP = 2'b00;
        tick();
        bus_a.RVALID = 1'b0;
        a_start = 1'b1;
        checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL busy_done: got done=%b rdata=%h required 1/0badf00d", a_done, a_rdata);
        end
        tick();
        a_start = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || bus_a.AWVALID !== 1'b0 || bus_a.ARVALID !== 1'b0) begin
            errors++;
            $display("FAIL done_start: got busy=%b awvalid=%b arvalid=%b required 0/0/0", a_busy, bus_a.AWVALID, bus_a.ARVALID);
        end
        tick();
        $display("read addr=00000300 rdata=%h with ignored Start pulses", a_rdata);
    endtask

    task automatic test_reset_mid_write();
        bit done_seen = 1'b0;
        bus_a.AWREADY = 1'b0; bus_a.WREADY = 1'b0;
        a_we = 1'b1; a_addr = 32'h44; a_wdata = 32'h1111_2222; a_wstrb = 4'hC; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre: got aw/w=%b required 11", {bus_a.AWVALID, bus_a.WVALID});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.AWVALID, bus_a.WVALID, a_busy, a_done} !== 4'b0000 || bus_a.AWADDR !== 32'h0 || bus_a.WDATA !== 32'h0 || a_rdata !== 32'h0 || a_resp !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got aw/w/busy/done=%b awaddr=%h wdata=%h rdata=%h resp=%b required all zero", {bus_a.AWVALID, bus_a.WVALID, a_busy, a_done}, bus_a.AWADDR, bus_a.WDATA, a_rdata, a_resp);
        end
        tick();
        rst_n = 1'b1;
        bus_a.AWREADY = 1'b1; bus_a.WREADY = 1'b1; bus_a.BVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_done || a_busy) done_seen = 1'b1;
        end
        bus_a.AWREADY = 1'b0; bus_a.WREADY = 1'b0; bus_a.BVALID = 1'b0;
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL rst_no_done: got Done/Busy after reset required none");
        end
        $display("write addr=00000044 aborted by reset");
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_start = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        bus_a.AWREADY = 1'b0; bus_a.WREADY = 1'b0; bus_a.BVALID = 1'b0; bus_a.BRESP = 2'b00;
        bus_a.ARREADY = 1'b0; bus_a.RVALID = 1'b0; bus_a.RDATA = '0; bus_a.RRESP = 2'b00;
        bus_b.AWREADY = 1'b0; bus_b.WREADY = 1'b0; bus_b.BVALID = 1'b0; bus_b.BRESP = 2'b00;
        bus_b.ARREADY = 1'b0; bus_b.RVALID = 1'b0; bus_b.RDATA = '0; bus_b.RRESP = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read_wait();
        test_write_64();
        test_timeout();
        test_start_ignored();
        test_reset_mid_write();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
